// File: rtl/sd_spi_arbiter_if.sv
// Bundle of the two requester-side SPI ports plus the SD card pins and the
// arbiter status outputs. The arbiter uses the slave view; whoever drives
// the requesters and the card model uses the master view.
interface sd_spi_arbiter_if;
    // Requester side, one bit per requester (0 = control MCU, 1 = guest core)
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] cs_n_in;
    logic [1:0] sck_in;
    logic [1:0] mosi_in;
    logic [1:0] miso_out;

    // SD card pins
    logic       sd_cs;
    logic       sd_sck;
    logic       sd_mosi;
    logic       sd_miso;

    // Status
    logic       owner;
    logic       busy;
    logic       timeout_pulse;

    modport slave (
        input  req,
        input  cs_n_in,
        input  sck_in,
        input  mosi_in,
        input  sd_miso,
        output gnt,
        output miso_out,
        output sd_cs,
        output sd_sck,
        output sd_mosi,
        output owner,
        output busy,
        output timeout_pulse
    );

    modport master (
        output req,
        output cs_n_in,
        output sck_in,
        output mosi_in,
        output sd_miso,
        input  gnt,
        input  miso_out,
        input  sd_cs,
        input  sd_sck,
        input  sd_mosi,
        input  owner,
        input  busy,
        input  timeout_pulse
    );
endinterface

// File: rtl/sd_spi_arbiter.sv
// Two-requester arbiter for the single SD-card SPI port.
// Whole transactions are granted (req is a level held for the ownership),
// a CS-high guard gap separates owners, and a watchdog reclaims the bus
// from an owner whose SCK and CS stop moving.
module sd_spi_arbiter #(
    parameter int unsigned GUARD_CYCLES = 8,      // 1..255 idle cycles after release
    parameter int unsigned TIMEOUT      = 65535   // 0 disables the watchdog
) (
    input  logic            clk,
    input  logic            reset,
    sd_spi_arbiter_if.slave bus
);

    // Last guard count value before returning to IDLE.
    localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYCLES - 1);
    // Watchdog count value at which the next idle edge forces a release.
    localparam logic [15:0] WD_LAST    = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit          WD_ENABLE  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;          // requester granted most recently
    logic        tp_q, tp_d;
    logic [1:0]  blocked_q, blocked_d;    // set by a watchdog release, cleared by req low
    logic [7:0]  guard_q, guard_d;
    logic [15:0] wd_q, wd_d;
    logic [1:0]  sck_prev_q;              // pin values at the previous edge,
    logic [1:0]  cs_prev_q;               // used to detect owner activity

    logic [1:0]  eligible;
    logic        winner;
    logic        owner_active;
    logic        wd_expire;
    logic        in_grant;
    logic [1:0]  miso_mux;

    // State register: all arbiter state, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 2'b00;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;   // requester 0 wins the first tie
            tp_q       <= 1'b0;
            blocked_q  <= 2'b00;
            guard_q    <= 8'd0;
            wd_q       <= 16'd0;
            sck_prev_q <= 2'b00;
            cs_prev_q  <= 2'b11;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            tp_q       <= tp_d;
            blocked_q  <= blocked_d;
            guard_q    <= guard_d;
            wd_q       <= wd_d;
            sck_prev_q <= bus.sck_in;
            cs_prev_q  <= bus.cs_n_in;
        end
    end

    // Arbitration: round-robin between eligible requesters.
    always_comb begin
        eligible = bus.req & ~blocked_q;
        if (eligible == 2'b11) begin
            winner = ~last_q;
        end else begin
            winner = eligible[1];
        end
    end

    // Watchdog: any change on the owner's SCK or CS counts as activity.
    always_comb begin
        owner_active = (bus.sck_in[owner_q]  != sck_prev_q[owner_q]) ||
                       (bus.cs_n_in[owner_q] != cs_prev_q[owner_q]);
        wd_expire    = WD_ENABLE && !owner_active && (wd_q == WD_LAST);
    end

    // Next-state logic for IDLE -> GRANT -> GUARD -> IDLE.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        tp_d      = 1'b0;
        guard_d   = guard_q;
        wd_d      = wd_q;
        // A requester that lets go of req becomes eligible again.
        blocked_d = blocked_q & bus.req;

        unique case (state_q)
            ST_IDLE: begin
                guard_d = 8'd0;
                wd_d    = 16'd0;
                if (eligible != 2'b00) begin
                    state_d = ST_GRANT;
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    owner_d = winner;
                    last_d  = winner;
                end
            end

            ST_GRANT: begin
                wd_d = owner_active ? 16'd0 : wd_q + 16'd1;
                // Expiry takes precedence over a release on the same edge,
                // so a stalled owner that happens to drop req is still blocked.
                if (wd_expire) begin
                    state_d            = ST_GUARD;
                    gnt_d              = 2'b00;
                    tp_d               = 1'b1;
                    blocked_d[owner_q] = 1'b1;
                    wd_d               = 16'd0;
                end else if (!bus.req[owner_q]) begin
                    state_d = ST_GUARD;
                    gnt_d   = 2'b00;
                    wd_d    = 16'd0;
                end
            end

            ST_GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = ST_IDLE;
                    guard_d = 8'd0;
                end else begin
                    guard_d = guard_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Output logic: pin mux driven from registered state so SPI edges pass straight through.
    always_comb begin
        in_grant = (state_q == ST_GRANT);
        if (in_grant) begin
            bus.sd_cs   = bus.cs_n_in[owner_q];
            bus.sd_sck  = bus.sck_in[owner_q];
            bus.sd_mosi = bus.mosi_in[owner_q];
        end else begin
            bus.sd_cs   = 1'b1;
            bus.sd_sck  = 1'b0;
            bus.sd_mosi = 1'b1;
        end
    end

    // MISO return: only the owner sees the card, everyone else reads idle-high.
    for (genvar gi = 0; gi < 2; gi++) begin : g_miso
        assign miso_mux[gi] = (in_grant && (owner_q == 1'(gi))) ? bus.sd_miso : 1'b1;
    end

    assign bus.miso_out      = miso_mux;
    assign bus.gnt           = gnt_q;
    assign bus.owner         = owner_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.timeout_pulse = tp_q;

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Bench for sd_spi_arbiter: a table of per-cycle vectors for a plain
// transfer, then hand-written sequences for guard timing, no-preemption,
// round-robin, watchdog, reset mid-transfer and a watchdog-disabled instance.
module tb_sd_spi_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sd_spi_arbiter_if bus_a ();
    sd_spi_arbiter_if bus_z ();

    sd_spi_arbiter #(.GUARD_CYCLES(8), .TIMEOUT(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    sd_spi_arbiter #(.GUARD_CYCLES(1), .TIMEOUT(0)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_z)
    );

    typedef struct {
        logic [1:0] req;
        logic [1:0] cs;
        logic [1:0] sck;
        logic [1:0] mosi;
        logic       miso;
        logic [1:0] e_gnt;
        logic       e_cs;
        logic       e_sck;
        logic       e_mosi;
        logic [1:0] e_miso;
        logic       e_busy;
        logic       e_tp;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic z_tp_seen = 1'b0;

    always @(posedge clk) begin
        if (bus_z.timeout_pulse !== 1'b0 && !reset) z_tp_seen <= 1'b1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_a(input logic [1:0] req, input logic [1:0] cs,
                         input logic [1:0] sck, input logic [1:0] mosi);
        bus_a.req     = req;
        bus_a.cs_n_in = cs;
        bus_a.sck_in  = sck;
        bus_a.mosi_in = mosi;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_a(2'b00, 2'b11, 2'b00, 2'b11);
        bus_a.sd_miso = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] cs,
                                input logic [1:0] sck, input logic [1:0] mosi,
                                input logic miso, input logic [1:0] e_gnt,
                                input logic e_cs, input logic e_sck, input logic e_mosi,
                                input logic [1:0] e_miso, input logic e_busy,
                                input logic e_tp);
        vec_t v;
        v.req = req; v.cs = cs; v.sck = sck; v.mosi = mosi; v.miso = miso;
        v.e_gnt = e_gnt; v.e_cs = e_cs; v.e_sck = e_sck; v.e_mosi = e_mosi;
        v.e_miso = e_miso; v.e_busy = e_busy; v.e_tp = e_tp;
        return v;
    endfunction

    initial begin
        logic [7:0] byte_v;
        logic       s1;
        logic       m1;

        bus_z.req = 2'b00; bus_z.cs_n_in = 2'b11; bus_z.sck_in = 2'b00;
        bus_z.mosi_in = 2'b11; bus_z.sd_miso = 1'b1;

        // ---- reset state ----
        do_reset();
        reset = 1'b1;
        tick();
        chk("rst.gnt",   16'(bus_a.gnt), 16'h0);
        chk("rst.owner", 16'(bus_a.owner), 16'h0);
        chk("rst.busy",  16'(bus_a.busy), 16'h0);
        chk("rst.tp",    16'(bus_a.timeout_pulse), 16'h0);
        chk("rst.sd_cs", 16'(bus_a.sd_cs), 16'h1);
        chk("rst.sd_sck", 16'(bus_a.sd_sck), 16'h0);
        chk("rst.sd_mosi", 16'(bus_a.sd_mosi), 16'h1);
        chk("rst.miso_out", 16'(bus_a.miso_out), 16'h3);
        reset = 1'b0;

        // ---- table: requester 0 clocks out 0x55, then releases ----
        byte_v = 8'h55;
        tbl.push_back(mk(2'b01, 2'b11, 2'b00, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0));
        tbl.push_back(mk(2'b01, 2'b10, 2'b00, {1'b1, byte_v[7]}, 1'b0,
                         2'b01, 1'b0, 1'b0, byte_v[7], 2'b10, 1'b1, 1'b0));
        for (int b = 7; b >= 0; b--) begin
            if (b != 7)
                tbl.push_back(mk(2'b01, 2'b10, 2'b00, {1'b1, byte_v[b]}, 1'b0,
                                 2'b01, 1'b0, 1'b0, byte_v[b], 2'b10, 1'b1, 1'b0));
            tbl.push_back(mk(2'b01, 2'b10, 2'b01, {1'b1, byte_v[b]}, 1'b0,
                             2'b01, 1'b0, 1'b1, byte_v[b], 2'b10, 1'b1, 1'b0));
        end
        tbl.push_back(mk(2'b01, 2'b11, 2'b00, 2'b11, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0));
        for (int k = 0; k < 7; k++)
            tbl.push_back(mk(2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 2'b11, 2'b00, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            set_a(tbl[i].req, tbl[i].cs, tbl[i].sck, tbl[i].mosi);
            bus_a.sd_miso = tbl[i].miso;
            tick();
            chk($sformatf("v%0d.gnt", i),      16'(bus_a.gnt),      16'(tbl[i].e_gnt));
            chk($sformatf("v%0d.sd_cs", i),    16'(bus_a.sd_cs),    16'(tbl[i].e_cs));
            chk($sformatf("v%0d.sd_sck", i),   16'(bus_a.sd_sck),   16'(tbl[i].e_sck));
            chk($sformatf("v%0d.sd_mosi", i),  16'(bus_a.sd_mosi),  16'(tbl[i].e_mosi));
            chk($sformatf("v%0d.miso_out", i), 16'(bus_a.miso_out), 16'(tbl[i].e_miso));
            chk($sformatf("v%0d.busy", i),     16'(bus_a.busy),     16'(tbl[i].e_busy));
            chk($sformatf("v%0d.tp", i),       16'(bus_a.timeout_pulse), 16'(tbl[i].e_tp));
        end

        // ---- simultaneous request: 0 wins, guard gap before 1 ----
        do_reset();
        set_a(2'b11, 2'b11, 2'b00, 2'b11);
        tick();
        chk("tie.gnt", 16'(bus_a.gnt), 16'h1);
        chk("tie.owner", 16'(bus_a.owner), 16'h0);
        set_a(2'b10, 2'b01, 2'b10, 2'b01);   // requester 1 pins active while waiting
        tick();
        chk("rel.gnt", 16'(bus_a.gnt), 16'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("guard%0d.gnt", k), 16'(bus_a.gnt), 16'h0);
            chk($sformatf("guard%0d.sd_cs", k), 16'(bus_a.sd_cs), 16'h1);
            chk($sformatf("guard%0d.sd_sck", k), 16'(bus_a.sd_sck), 16'h0);
        end
        tick();
        chk("g1.gnt", 16'(bus_a.gnt), 16'h2);
        chk("g1.owner", 16'(bus_a.owner), 16'h1);
        chk("g1.sd_cs", 16'(bus_a.sd_cs), 16'h0);
        chk("g1.sd_sck", 16'(bus_a.sd_sck), 16'h1);
        chk("g1.sd_mosi", 16'(bus_a.sd_mosi), 16'h0);

        // ---- no preemption: requester 0 asks while 1 transfers (longer than TIMEOUT) ----
        for (int k = 0; k < 24; k++) begin
            s1 = k[0];
            m1 = k[1];
            set_a(2'b11, 2'b00, {s1, ~s1}, {m1, ~m1});
            tick();
            chk($sformatf("np%0d.gnt", k), 16'(bus_a.gnt), 16'h2);
            chk($sformatf("np%0d.sd_sck", k), 16'(bus_a.sd_sck), 16'(s1));
            chk($sformatf("np%0d.sd_mosi", k), 16'(bus_a.sd_mosi), 16'(m1));
        end
        chk("np.sd_cs", 16'(bus_a.sd_cs), 16'h0);
        set_a(2'b01, 2'b11, 2'b00, 2'b11);
        tick();
        chk("np_rel.gnt", 16'(bus_a.gnt), 16'h0);
        chk("np_rel.owner", 16'(bus_a.owner), 16'h1);
        for (int k = 0; k < 8; k++) tick();
        chk("np_gap.gnt", 16'(bus_a.gnt), 16'h0);
        tick();
        chk("np_next.gnt", 16'(bus_a.gnt), 16'h1);

        // ---- round-robin: both eligible after 0 owned, so 1 wins ----
        set_a(2'b00, 2'b11, 2'b00, 2'b11);
        tick();
        chk("rr_rel.gnt", 16'(bus_a.gnt), 16'h0);
        set_a(2'b11, 2'b11, 2'b00, 2'b11);
        for (int k = 0; k < 8; k++) tick();
        chk("rr_gap.gnt", 16'(bus_a.gnt), 16'h0);
        tick();
        chk("rr.gnt", 16'(bus_a.gnt), 16'h2);

        // ---- watchdog: requester 1 idle for 16 cycles ----
        do_reset();
        set_a(2'b10, 2'b11, 2'b00, 2'b11);
        tick();
        chk("wd.grant", 16'(bus_a.gnt), 16'h2);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("wd%0d.tp", k), 16'(bus_a.timeout_pulse), 16'h0);
            chk($sformatf("wd%0d.gnt", k), 16'(bus_a.gnt), 16'h2);
        end
        tick();
        chk("wd16.tp", 16'(bus_a.timeout_pulse), 16'h1);
        chk("wd16.gnt", 16'(bus_a.gnt), 16'h0);
        chk("wd16.busy", 16'(bus_a.busy), 16'h1);
        tick();
        chk("wd17.tp", 16'(bus_a.timeout_pulse), 16'h0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("blk%0d.gnt", k), 16'(bus_a.gnt), 16'h0);
        end
        set_a(2'b00, 2'b11, 2'b00, 2'b11);
        tick();
        set_a(2'b10, 2'b11, 2'b00, 2'b11);
        tick();
        chk("unblk.gnt", 16'(bus_a.gnt), 16'h2);

        // ---- req drop on the expiry edge still counts as a timeout ----
        for (int k = 1; k <= 15; k++) tick();
        chk("sim.pre_gnt", 16'(bus_a.gnt), 16'h2);
        set_a(2'b00, 2'b11, 2'b00, 2'b11);
        tick();
        chk("sim.tp", 16'(bus_a.timeout_pulse), 16'h1);
        set_a(2'b10, 2'b11, 2'b00, 2'b11);
        for (int k = 0; k < 15; k++) tick();
        chk("sim.blocked_gnt", 16'(bus_a.gnt), 16'h0);
        set_a(2'b00, 2'b11, 2'b00, 2'b11);
        tick();

        // ---- reset mid-byte ----
        do_reset();
        set_a(2'b01, 2'b11, 2'b00, 2'b11);
        tick();
        chk("mr.gnt", 16'(bus_a.gnt), 16'h1);
        for (int k = 0; k < 3; k++) begin
            set_a(2'b01, 2'b10, {1'b0, k[0]}, {1'b1, k[1]});
            tick();
        end
        chk("mr.sd_cs_low", 16'(bus_a.sd_cs), 16'h0);
        reset = 1'b1;
        tick();
        chk("mr.sd_cs", 16'(bus_a.sd_cs), 16'h1);
        chk("mr.sd_sck", 16'(bus_a.sd_sck), 16'h0);
        chk("mr.gnt0", 16'(bus_a.gnt), 16'h0);
        chk("mr.busy", 16'(bus_a.busy), 16'h0);
        reset = 1'b0;
        tick();
        chk("mr.regrant", 16'(bus_a.gnt), 16'h1);
        chk("mr.sd_cs_again", 16'(bus_a.sd_cs), 16'h0);

        // ---- watchdog disabled, guard of 1 ----
        bus_z.req = 2'b01;
        tick();
        chk("z.gnt", 16'(bus_z.gnt), 16'h1);
        for (int k = 0; k < 5000; k++) tick();
        chk("z.hold_gnt", 16'(bus_z.gnt), 16'h1);
        chk("z.no_tp", 16'(z_tp_seen), 16'h0);
        bus_z.req = 2'b00;
        tick();
        chk("z.rel", 16'(bus_z.gnt), 16'h0);
        bus_z.req = 2'b01;
        tick();
        chk("z.gap", 16'(bus_z.gnt), 16'h0);
        tick();
        chk("z.regrant", 16'(bus_z.gnt), 16'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
